// File: rtl/lsu_types_pkg.sv
// Shared LSU type definitions: performance-monitor FSM encoding and ratio scale.
package lsu_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } perf_fsm_e;

    localparam int PERF_SCALE = 100;

endpackage

// File: rtl/perf_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, W cycles after start.
module perf_seq_divider
    import lsu_types::*;
#(
    parameter int W = 39
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic         dz
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          dz_q, dz_d;
    logic [W:0]    rem_sh;
    logic          ge;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        dz_d   = dz_q;
        rem_sh = {rem_q, quo_q[W-1]};
        ge     = (rem_sh >= {1'b0, div_q});

        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
            dz_d   = (divisor == '0);
        end else if (busy_q) begin
            // The difference always fits in W bits when ge holds, so wrap is safe.
            rem_d = ge ? (rem_sh[W-1:0] - div_q) : rem_sh[W-1:0];
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            dz_q   <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CW'(1));
    assign quotient = quo_q;
    assign dz       = dz_q;

endmodule

// File: rtl/perf_window_monitor.sv
// Windowed LSU event counters with snapshot and a sequential percentage ratio.
module perf_window_monitor
    import lsu_types::*;
#(
    parameter int NUM_EVT = 8,
    parameter int CNT_W   = 32,
    parameter int WIN_W   = 16,
    parameter int IDX_W   = $clog2(NUM_EVT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic [WIN_W-1:0]   win_len_i,
    input  logic               snap_i,
    input  logic [IDX_W-1:0]   num_sel_i,
    input  logic [IDX_W-1:0]   den_sel_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               win_done_o,
    output logic [CNT_W-1:0]   ratio_o,
    output logic               ratio_valid_o,
    output logic               div_zero_o,
    output logic               busy_o,
    output logic [NUM_EVT-1:0] ovf_o
);

    localparam int DW = CNT_W + 7;

    logic [CNT_W-1:0]   live_q [NUM_EVT];
    logic [CNT_W-1:0]   live_d [NUM_EVT];
    logic [CNT_W-1:0]   snap_q [NUM_EVT];
    logic [CNT_W-1:0]   snap_d [NUM_EVT];
    logic [NUM_EVT-1:0] ovf_q, ovf_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               pend_q, pend_d;
    perf_fsm_e          fsm_q, fsm_d;
    logic [CNT_W-1:0]   ratio_q, ratio_d;
    logic               ratio_valid_q, ratio_valid_d;
    logic               div_zero_q, div_zero_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic               win_done_q;
    logic               win_end;

    logic [CNT_W-1:0]   num_val, den_val;
    logic [DW-1:0]      dv_quo;
    logic               dv_busy, dv_done, dv_dz;

    // Out-of-range indices fall through the loop and return zero.
    function automatic logic [CNT_W-1:0] pick(input logic [CNT_W-1:0] arr [NUM_EVT],
                                              input logic [IDX_W-1:0] idx);
        pick = '0;
        for (int i = 0; i < NUM_EVT; i++)
            if (idx == IDX_W'(i)) pick = arr[i];
    endfunction

    assign num_val = pick(snap_q, num_sel_i);
    assign den_val = pick(snap_q, den_sel_i);

    perf_seq_divider #(.W(DW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (fsm_q == LOAD),
        .dividend (DW'(num_val) * DW'(PERF_SCALE)),
        .divisor  (DW'(den_val)),
        .busy     (dv_busy),
        .done     (dv_done),
        .quotient (dv_quo),
        .dz       (dv_dz)
    );

    always_comb begin
        live_d        = live_q;
        snap_d        = snap_q;
        ovf_d         = ovf_q;
        win_cnt_d     = win_cnt_q;
        pend_d        = pend_q;
        fsm_d         = fsm_q;
        ratio_d       = ratio_q;
        ratio_valid_d = ratio_valid_q;
        div_zero_d    = div_zero_q;
        win_end       = snap_i || (enable_i && (win_len_i != '0) &&
                                   (win_cnt_q == win_len_i - WIN_W'(1)));

        // The closing cycle's events land in the snapshot, not the next window.
        for (int i = 0; i < NUM_EVT; i++) begin
            if (enable_i && evt_i[i]) begin
                if (&live_q[i]) ovf_d[i] = 1'b1;
                else            live_d[i] = live_q[i] + CNT_W'(1);
            end
            if (win_end) begin
                snap_d[i] = live_d[i];
                live_d[i] = '0;
            end
        end

        if (win_end)       win_cnt_d = '0;
        else if (enable_i) win_cnt_d = win_cnt_q + WIN_W'(1);

        unique case (fsm_q)
            IDLE: if (win_end) fsm_d = LOAD;
            LOAD: begin
                ratio_valid_d = 1'b0;
                fsm_d         = DIV;
                if (win_end) pend_d = 1'b1;
            end
            DIV: begin
                if (dv_done || !dv_busy) fsm_d = DONE;
                if (win_end) pend_d = 1'b1;
            end
            DONE: begin
                if (dv_dz) begin
                    ratio_d    = '0;
                    div_zero_d = 1'b1;
                end else begin
                    ratio_d    = (|dv_quo[DW-1:CNT_W]) ? '1 : dv_quo[CNT_W-1:0];
                    div_zero_d = 1'b0;
                end
                ratio_valid_d = 1'b1;
                fsm_d         = (pend_q || win_end) ? LOAD : IDLE;
                pend_d        = 1'b0;
            end
            default: fsm_d = IDLE;
        endcase

        if (clear_i) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                live_d[i] = '0;
                snap_d[i] = '0;
            end
            ovf_d         = '0;
            win_cnt_d     = '0;
            pend_d        = 1'b0;
            fsm_d         = IDLE;
            ratio_d       = '0;
            ratio_valid_d = 1'b0;
            div_zero_d    = 1'b0;
        end

        rd_data_d = pick(snap_d, rd_idx_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: counter/snapshot arrays are reset because readers expect zeros.
            for (int i = 0; i < NUM_EVT; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
            ovf_q         <= '0;
            win_cnt_q     <= '0;
            pend_q        <= 1'b0;
            fsm_q         <= IDLE;
            ratio_q       <= '0;
            ratio_valid_q <= 1'b0;
            div_zero_q    <= 1'b0;
            rd_data_q     <= '0;
            win_done_q    <= 1'b0;
        end else begin
            live_q        <= live_d;
            snap_q        <= snap_d;
            ovf_q         <= ovf_d;
            win_cnt_q     <= win_cnt_d;
            pend_q        <= pend_d;
            fsm_q         <= fsm_d;
            ratio_q       <= ratio_d;
            ratio_valid_q <= ratio_valid_d;
            div_zero_q    <= div_zero_d;
            rd_data_q     <= rd_data_d;
            win_done_q    <= win_end && !clear_i;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign win_done_o    = win_done_q;
    assign ratio_o       = ratio_q;
    assign ratio_valid_o = ratio_valid_q;
    assign div_zero_o    = div_zero_q;
    assign busy_o        = (fsm_q != IDLE);
    assign ovf_o         = ovf_q;

endmodule

// File: doc/perf_window_monitor.md
# perf_window_monitor

Parametrised, windowed performance monitor for the LSU. It counts NUM_EVT single-bit event streams (loads, stores, forwards, violations, bloom hits, predictions, etc.) in saturating counters, and snapshots them at the end of each programmable sampling window or on request. After each snapshot it computes one selectable percentage ratio (num×100/den) with a sequential divider. It sits beside the LSQ and disambiguation logic and is read by the debug/CSR layer.

## Interface
Parameters:
- NUM_EVT, 8: number of event channels
- CNT_W, 32: counter, snapshot and ratio width
- WIN_W, 16: window-length width
- IDX_W, $clog2(NUM_EVT): channel index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- evt_i  in  NUM_EVT  per-channel event pulse; each set bit adds +1 this cycle
- enable_i  in  1  counting enable; low freezes live counters and window counter
- clear_i  in  1  synchronous clear of all state
- win_len_i  in  WIN_W  window length in enabled cycles; 0 disables automatic windows
- snap_i  in  1  manual snapshot request
- num_sel_i / den_sel_i  in  IDX_W  ratio numerator/denominator channels, sampled in LOAD
- rd_idx_i  in  IDX_W  snapshot read index
- rd_data_o  out  CNT_W  registered snapshot of channel rd_idx_i
- win_done_o  out  1  one-cycle pulse when a snapshot is taken
- ratio_o  out  CNT_W  last computed ratio
- ratio_valid_o  out  1  ratio_o valid
- div_zero_o  out  1  last ratio had den == 0
- busy_o  out  1  divider FSM not IDLE
- ovf_o  out  NUM_EVT  sticky per-channel saturation flags

## Operation
- Live counters: +1 per set evt_i bit when enable_i=1. They saturate at all-ones and set ovf_o[i] sticky. ovf_o clears only on reset/clear_i.
- Window counter: counts enabled cycles. A window ends on the enabled cycle where the count == win_len_i−1, or on any cycle with snap_i=1. This includes win_len_i=0 (manual only) and enable_i=0.
- At window end:
  - snapshot[i] ← live[i] including that cycle's events
  - live[i] ← 0
  - window counter ← 0
  - win_done_o pulses in the following cycle
- FSM states: IDLE, LOAD, DIV, DONE.
  - IDLE → LOAD at the window-end edge.
  - LOAD: latch dividend = snapshot[num_sel_i]×100, D = CNT_W+7 bits wide, and divisor = snapshot[den_sel_i]; ratio_valid_o ← 0.
  - DIV: restoring division, one quotient bit per cycle, exactly D cycles.
  - DONE: write ratio_o. If the quotient exceeds CNT_W bits, ratio_o = all-ones. If den == 0: ratio_o=0 and div_zero_o=1; otherwise div_zero_o=0. Set ratio_valid_o.
  - DONE → LOAD if a request is pending, else IDLE.
- Window end while busy_o: the snapshot still updates and a one-deep pending flag is set. Further ends only overwrite the snapshot, so the pending division uses the latest snapshot.
- clear_i: takes priority over events, snap_i and window end. It zeroes live, snapshot, ovf_o, window counter, pending, ratio_o, ratio_valid_o and div_zero_o, and forces the FSM to IDLE (aborting any division). win_done_o does not pulse.
- rd_idx_i ≥ NUM_EVT reads 0.

## Timing
- Reset values: all outputs 0, FSM IDLE, all counters/snapshots 0.
- rd_data_o: registered. It reflects snapshot[rd_idx_i] of cycle t in cycle t+1, including a snapshot written at the edge ending cycle t.
- With win_done_o high in cycle T (FSM in LOAD):
  - DIV occupies T+1 … T+CNT_W+7
  - DONE at T+CNT_W+8
  - ratio_valid_o rises at T+CNT_W+9 (41 cycles for CNT_W=32)
- busy_o is high in LOAD/DIV/DONE.
- ratio_valid_o is a level signal, held until the next LOAD or clear_i.
- Saturation, clear and window end are evaluated in the same cycle. A saturated counter at window end snapshots as all-ones.

## Structure
- Package lsu_types gains perf_fsm_e (IDLE/LOAD/DIV/DONE) and localparam PERF_SCALE = 100.
- Sub-module perf_seq_divider, parameter W, with ports start, dividend, divisor, busy, done, quotient, dz. It holds the restoring-division datapath. The top level owns counters, windowing and the FSM sequencing.

## Test plan
- win_len_i=10, evt_i[0] high 10 enabled cycles, evt_i[1] high 4 of them, num=1, den=0 → win_done_o after cycle 10; snapshot = 10 and 4; ratio_o=40 exactly 41 cycles later; live counters restart at 0.
- CNT_W=8, evt_i[2] high 300 cycles → counter holds 255, ovf_o[2]=1 until clear_i; snapshot reads 255.
- den channel with zero events, snap_i → ratio_o=0, div_zero_o=1, ratio_valid_o=1.
- snap_i twice 5 cycles apart, second with num count 7/den 7 → first division completes, then second yields ratio_o=100 without a further snap_i.
- clear_i during DIV → busy_o=0 and ratio_valid_o=0 next cycle, all counters 0, no win_done_o.
- Async rst_n low mid-window with counts 50 → all outputs 0 immediately; after release, rd_data_o=0 for every index, including index NUM_EVT.
